// File: rtl/id_ex_if.sv
// Decode-side inputs, execute-side register outputs and hazard controls
// exchanged between the ID/EX boundary and its neighbours.
interface id_ex_if;
  logic        RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
  logic [1:0]  ResultSrcD;
  logic [2:0]  ALUControlD;
  logic [31:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic        PCSrcE;

  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;
  logic        ValidE;
  logic        StallF, StallD, FlushD;

  modport master (
    output RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
           RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
           StallF, StallD, FlushD
  );

  modport slave (
    input  RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ResultSrcD, ALUControlD,
           RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, PCSrcE,
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE,
           RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
           StallF, StallD, FlushD
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and branch flush.
// A bubble clears every execute field, so it behaves as a NOP downstream.
module id_ex_stage (
  input logic   CLK,
  input logic   RST,
  id_ex_if.slave bus
);

  logic lw_stall;
  logic bubble;

  // A taken branch overrides a load-use hit: the dependent instruction is flushed anyway.
  always_comb begin
    lw_stall = (bus.ResultSrcE == 2'b01) & bus.ValidE & (bus.RdE != 5'd0) &
               ((bus.Rs1D == bus.RdE) | (bus.Rs2D == bus.RdE)) & ~bus.PCSrcE;
    bubble   = lw_stall | bus.PCSrcE;
  end

  assign bus.StallF = lw_stall;
  assign bus.StallD = lw_stall;
  assign bus.FlushD = bus.PCSrcE & RST;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST || bubble) begin
      bus.RegWriteE   <= 1'b0;
      bus.MemWriteE   <= 1'b0;
      bus.JumpE       <= 1'b0;
      bus.BranchE     <= 1'b0;
      bus.ALUSrcE     <= 1'b0;
      bus.ResultSrcE  <= 2'b00;
      bus.ALUControlE <= 3'b000;
      bus.RD1E        <= 32'd0;
      bus.RD2E        <= 32'd0;
      bus.PCE         <= 32'd0;
      bus.ImmExtE     <= 32'd0;
      bus.PCPlus4E    <= 32'd0;
      bus.Rs1E        <= 5'd0;
      bus.Rs2E        <= 5'd0;
      bus.RdE         <= 5'd0;
      bus.ValidE      <= 1'b0;
    end else begin
      bus.RegWriteE   <= bus.RegWriteD;
      bus.MemWriteE   <= bus.MemWriteD;
      bus.JumpE       <= bus.JumpD;
      bus.BranchE     <= bus.BranchD;
      bus.ALUSrcE     <= bus.ALUSrcD;
      bus.ResultSrcE  <= bus.ResultSrcD;
      bus.ALUControlE <= bus.ALUControlD;
      bus.RD1E        <= bus.RD1D;
      bus.RD2E        <= bus.RD2D;
      bus.PCE         <= bus.PCD;
      bus.ImmExtE     <= bus.ImmExtD;
      bus.PCPlus4E    <= bus.PCPlus4D;
      bus.Rs1E        <= bus.Rs1D;
      bus.Rs2E        <= bus.Rs2D;
      bus.RdE         <= bus.RdD;
      bus.ValidE      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a field-level model of the execute slot is
// compared every negative edge, plus literal checks at the interesting moments.
module tb_id_ex_stage;

  typedef struct packed {
    logic        reg_write, mem_write, jump, branch, alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_control;
    logic [31:0] rd1, rd2, pc, imm_ext, pc_plus4;
    logic [4:0]  rs1, rs2, rd;
  } slot_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  id_ex_if bus ();

  id_ex_stage dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  function automatic slot_t decode_slot();
    return '{bus.RegWriteD, bus.MemWriteD, bus.JumpD, bus.BranchD, bus.ALUSrcD,
             bus.ResultSrcD, bus.ALUControlD, bus.RD1D, bus.RD2D, bus.PCD,
             bus.ImmExtD, bus.PCPlus4D, bus.Rs1D, bus.Rs2D, bus.RdD};
  endfunction

  function automatic slot_t exec_slot();
    return '{bus.RegWriteE, bus.MemWriteE, bus.JumpE, bus.BranchE, bus.ALUSrcE,
             bus.ResultSrcE, bus.ALUControlE, bus.RD1E, bus.RD2E, bus.PCE,
             bus.ImmExtE, bus.PCPlus4E, bus.Rs1E, bus.Rs2E, bus.RdE};
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of the execute slot: what instruction occupies it, if any.
  slot_t m_slot = '0;
  logic  m_valid = 1'b0;

  function automatic logic m_load_use();
    logic uses;
    uses = (bus.Rs1D == m_slot.rd) || (bus.Rs2D == m_slot.rd);
    return m_valid && m_slot.result_src == 2'b01 && m_slot.rd != 5'd0 && uses && !bus.PCSrcE;
  endfunction

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_slot  <= '0;
      m_valid <= 1'b0;
    end else if (m_load_use() || bus.PCSrcE) begin
      m_slot  <= '0;
      m_valid <= 1'b0;
    end else begin
      m_slot  <= decode_slot();
      m_valid <= 1'b1;
    end
  end

  always @(negedge CLK) begin
    check("exec_slot", 192'(exec_slot()), 192'(m_slot));
    check("valid",  192'(bus.ValidE), 192'(m_valid));
    check("stallf", 192'(bus.StallF), 192'(m_load_use() && RST));
    check("stalld", 192'(bus.StallD), 192'(m_load_use() && RST));
    check("flushd", 192'(bus.FlushD), 192'(bus.PCSrcE && RST));
  end

  task automatic apply(input logic rw, input logic [1:0] rsrc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] rd1,
                       input logic pcsrc);
    bus.RegWriteD   = rw;
    bus.MemWriteD   = rd1[0];
    bus.JumpD       = rd1[1];
    bus.BranchD     = rd1[2];
    bus.ALUSrcD     = rd1[3];
    bus.ResultSrcD  = rsrc;
    bus.ALUControlD = rd1[6:4];
    bus.RD1D        = rd1;
    bus.RD2D        = ~rd1;
    bus.PCD         = {rd1[15:0], rd1[31:16]};
    bus.ImmExtD     = rd1 + 32'd1;
    bus.PCPlus4D    = rd1 + 32'd4;
    bus.Rs1D        = rs1;
    bus.Rs2D        = rs2;
    bus.RdD         = rd;
    bus.PCSrcE      = pcsrc;
    $display("apply t=%0t rw=%0b rsrc=%0b rs1=%0d rs2=%0d rd=%0d rd1=%08h pcsrc=%0b",
             $time, rw, rsrc, rs1, rs2, rd, rd1, pcsrc);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with a live decode word: nothing may leak through.
    apply(1'b1, 2'b00, 5'd0, 5'd0, 5'd0, 32'h0000_1234, 1'b0);
    #1;
    check("rst_valid", 192'(bus.ValidE), 192'd0);
    check("rst_regwrite", 192'(bus.RegWriteE), 192'd0);
    check("rst_rd1", 192'(bus.RD1E), 192'd0);
    check("rst_stall", 192'(bus.StallF), 192'd0);
    tick();
    RST = 1'b1;
    tick();
    check("pass_regwrite", 192'(bus.RegWriteE), 192'd1);
    check("pass_rd1", 192'(bus.RD1E), 192'h0000_1234);
    check("pass_rd2", 192'(bus.RD2E), 192'hFFFF_EDCB);
    check("pass_valid", 192'(bus.ValidE), 192'd1);

    // lw x5 into execute, then a consumer of x5 in decode.
    apply(1'b1, 2'b01, 5'd2, 5'd0, 5'd5, 32'h0000_0100, 1'b0);
    tick();
    check("lw_rdE", 192'(bus.RdE), 192'd5);
    apply(1'b1, 2'b00, 5'd6, 5'd5, 5'd8, 32'h0000_AAAA, 1'b0);
    #1;
    check("lu_stallf", 192'(bus.StallF), 192'd1);
    check("lu_stalld", 192'(bus.StallD), 192'd1);
    check("lu_flushd", 192'(bus.FlushD), 192'd0);
    tick();
    check("lu_bubble_valid", 192'(bus.ValidE), 192'd0);
    check("lu_bubble_rw", 192'(bus.RegWriteE), 192'd0);
    check("lu_stall_clear", 192'(bus.StallF), 192'd0);
    tick();
    check("lu_held_rd", 192'(bus.RdE), 192'd8);
    check("lu_held_rd1", 192'(bus.RD1E), 192'h0000_AAAA);
    check("lu_held_valid", 192'(bus.ValidE), 192'd1);

    // Load to x0 never stalls, even when decode reads x0.
    apply(1'b1, 2'b01, 5'd1, 5'd1, 5'd0, 32'h0000_0200, 1'b0);
    tick();
    apply(1'b1, 2'b01, 5'd0, 5'd0, 5'd7, 32'h0000_0300, 1'b0);
    #1;
    check("x0_nostall", 192'(bus.StallF), 192'd0);
    tick();
    // Load to x7 followed by an independent instruction.
    apply(1'b0, 2'b00, 5'd3, 5'd4, 5'd9, 32'h0000_0400, 1'b0);
    #1;
    check("indep_nostall", 192'(bus.StallF), 192'd0);
    tick();
    check("indep_valid", 192'(bus.ValidE), 192'd1);

    // Taken branch with a real instruction in decode.
    apply(1'b1, 2'b00, 5'd10, 5'd11, 5'd12, 32'hDEAD_BEEF, 1'b1);
    #1;
    check("br_flushd", 192'(bus.FlushD), 192'd1);
    check("br_stallf", 192'(bus.StallF), 192'd0);
    tick();
    check("br_valid", 192'(bus.ValidE), 192'd0);
    check("br_rd1", 192'(bus.RD1E), 192'd0);
    check("br_rdE", 192'(bus.RdE), 192'd0);

    // Load in execute matching Rs1D while a branch is taken: flush wins.
    apply(1'b1, 2'b01, 5'd1, 5'd2, 5'd9, 32'h0000_0500, 1'b0);
    tick();
    apply(1'b1, 2'b00, 5'd9, 5'd3, 5'd4, 32'h0000_0600, 1'b1);
    #1;
    check("conf_stallf", 192'(bus.StallF), 192'd0);
    check("conf_flushd", 192'(bus.FlushD), 192'd1);
    tick();
    check("conf_valid", 192'(bus.ValidE), 192'd0);

    // Asynchronous reset while execute holds a valid instruction.
    apply(1'b1, 2'b00, 5'd1, 5'd2, 5'd3, 32'h1357_9BDF, 1'b0);
    tick();
    check("pre_rst_valid", 192'(bus.ValidE), 192'd1);
    #2;
    RST = 1'b0;
    #1;
    check("arst_valid", 192'(bus.ValidE), 192'd0);
    check("arst_rd1", 192'(bus.RD1E), 192'd0);
    check("arst_regwrite", 192'(bus.RegWriteE), 192'd0);
    tick();
    RST = 1'b1;

    // Reset in the middle of a load-use stall.
    apply(1'b1, 2'b01, 5'd1, 5'd2, 5'd12, 32'h0000_0700, 1'b0);
    tick();
    apply(1'b1, 2'b00, 5'd12, 5'd0, 5'd13, 32'h0000_0800, 1'b0);
    #1;
    check("ms_stall", 192'(bus.StallF), 192'd1);
    #1;
    RST = 1'b0;
    #1;
    check("ms_stall_gone", 192'(bus.StallF), 192'd0);
    check("ms_valid", 192'(bus.ValidE), 192'd0);
    check("ms_result_src", 192'(bus.ResultSrcE), 192'd0);
    tick();
    RST = 1'b1;
    tick();
    check("ms_restart_rd", 192'(bus.RdE), 192'd13);
    check("ms_restart_valid", 192'(bus.ValidE), 192'd1);

    // Short mixed sequence covered by the per-cycle model comparison.
    for (int i = 0; i < 12; i++) begin
      apply(1'(i % 2), 2'(i % 3), 5'(i % 5), 5'((i + 2) % 6), 5'(i % 4),
            32'h1000_0000 + 32'(i * 32'h0101_0101), 1'(i == 7));
      tick();
    end

    @(negedge CLK);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode-to-execute pipeline boundary for the 5-stage RV32I core. It registers the main decoder's control word together with the decode-stage operands into the execute stage. It also contains the load-use hazard detector and the branch/jump flush logic. Sits directly downstream of the main decoder and the ALU decoder, and feeds the ALU, the branch comparator and the EX/MEM register.

## Interface
- No parameters; data width fixed at 32, register index width 5.
- `CLK`  in  1  rising-edge clock.
- `RST`  in  1  asynchronous active-low reset.
- `RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD`  in  1 each  decoded control bits from the main decoder.
- `ResultSrcD`  in  2  result mux select; `01` means load.
- `ALUControlD`  in  3  from the ALU decoder.
- `RD1D, RD2D, PCD, ImmExtD, PCPlus4D`  in  32 each  decode-stage operands.
- `Rs1D, Rs2D, RdD`  in  5 each  register indices of the instruction in decode.
- `PCSrcE`  in  1  taken branch or jump resolved in execute.
- `RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE`  out  same widths as D inputs  registered execute-stage copies.
- `ValidE`  out  1  execute slot holds a real instruction (0 = bubble).
- `StallF, StallD`  out  1  hold the PC and IF/ID registers.
- `FlushD`  out  1  clear the IF/ID register.

## Operation
- Internal `lwStall` = (`ResultSrcE`==`01`) & `ValidE` & (`RdE`!=0) & ((`Rs1D`==`RdE`) | (`Rs2D`==`RdE`)) & ~`PCSrcE`.
- `StallF` = `StallD` = `lwStall`.
- `FlushD` = `PCSrcE`.
- Internal `bubble` = `lwStall` | `PCSrcE`.
- Every rising `CLK`, when `bubble`=0: all E outputs load their D counterparts and `ValidE` becomes 1.
- Every rising `CLK`, when `bubble`=1: all E outputs become 0, including data and indices. `ValidE` becomes 0.
- A bubble is a NOP: no register write, no memory write, no branch, no jump.
- `Rs*D`==0 never causes a stall, because `RdE`!=0 is required.
- A load followed by an instruction that uses neither source register produces no stall.
- `PCSrcE` and a load in execute are mutually exclusive by construction. If both are seen, flush takes priority and `lwStall` is suppressed.
- No state beyond the execute register set; no FSM beyond the valid/bubble bit.

## Timing
- Register latency: 1 cycle from D inputs to E outputs.
- `StallF`, `StallD` and `FlushD` are combinational from the current E registers plus the current D inputs, valid in the same cycle.
- Load-use costs exactly 1 bubble. In the next cycle `ResultSrcE`=`00`, so the stall deasserts and the held instruction advances.
- Taken branch costs 2 slots: `FlushD` clears IF/ID and this block bubbles execute on the same edge.
- Reset: while `RST`=0, every registered output is 0 immediately, without waiting for `CLK`. `StallF`, `StallD` and `FlushD` evaluate to 0.
- Reset deassertion is synchronised upstream. The first edge after release captures the D inputs normally.
- Reset mid-stall: the stall is abandoned and execute is empty.

## Test plan
- Reset then pass-through: with `RST` low, drive `RegWriteD`=1, `RD1D`=0x1234. All outputs read 0 before any clock. Release reset. After 1 edge, `RegWriteE`=1, `RD1E`=0x00001234 and `ValidE`=1.
- Load-use stall: `lw x5` in execute (`ResultSrcE`=`01`, `RdE`=5), decode `Rs2D`=5. Required: `StallF`=`StallD`=1 in that cycle. Next edge gives `ValidE`=0 and `RegWriteE`=0. The following edge captures the held instruction and the stall clears.
- x0 and non-dependent cases:
  - Load with `RdE`=0 and `Rs1D`=0 gives no stall.
  - Load with `RdE`=7 and decode sources 3 and 4 gives no stall.
- Branch flush: `PCSrcE`=1 with a valid decode instruction. Required: `FlushD`=1, `StallF`=0. Next edge gives all E outputs 0 and `ValidE`=0.
- Forced conflict: load in execute matching `Rs1D` while `PCSrcE`=1. Required: `StallF`=0, `FlushD`=1, and a bubble on the next edge.
- Async reset mid-operation: assert `RST` low between clock edges with `ValidE`=1. Required: all E outputs and `ValidE` go to 0 within the same cycle, not at the next edge.
